mul_share_arbiter_taint: RTL

Round-robin arbiter and sequencer that shares one taint-tracked sequential multiplier (multiplier control + datapath) among NREQ requesters. It captures a winning request, launches the multiplier with a one-cycle start pulse, waits for productDone, and returns the product to the winner. Word-level taint is propagated through the arbitration decision, so any tainted request line taints the grant and everything downstream of it.

---
 rtl/mul_share_arbiter_taint.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter_taint.sv
// Round-robin sharing of one sequential multiplier among NREQ requesters,
// with word-level taint carried through the grant decision.
module mul_share_arbiter_taint #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_t,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ-1:0]       op_t,
    output logic                  mul_start,
    output logic                  mul_start_t,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    output logic                  mul_op_t,
    input  logic                  mul_done,
    input  logic                  mul_done_t,
    input  logic [2*WIDTH-1:0]    mul_product,
    input  logic                  mul_product_t,
    output logic [NREQ-1:0]       resp_valid,
    output logic                  resp_valid_t,
    output logic [2*WIDTH-1:0]    resp_product,
    output logic                  resp_product_t,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_e;

    state_e               r_state;
    state_e               w_next;
    logic [IW-1:0]        r_rr;
    logic [IW-1:0]        r_gnt;
    logic [IW-1:0]        w_gnt;
    logic                 w_found;
    logic                 w_grant_t;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_op_t;
    logic                 r_state_t;
    logic                 r_rv_t;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_prod_t;

    // first set req bit at or above r_rr, wrapping to 0
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(r_rr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!w_found && req[j]) begin
                w_gnt   = IW'(j);
                w_found = 1'b1;
            end
        end
    end

    // every req bit influences who wins, so any tainted one taints the grant
    assign w_grant_t = |req_t;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (|req) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (mul_done) w_next = RESPOND;
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr      <= '0;
            r_gnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op_t    <= 1'b0;
            r_state_t <= 1'b0;
            r_rv_t    <= 1'b0;
            r_prod    <= '0;
            r_prod_t  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt     <= w_gnt;
                        r_a       <= op_a[w_gnt*WIDTH +: WIDTH];
                        r_b       <= op_b[w_gnt*WIDTH +: WIDTH];
                        r_op_t    <= op_t[w_gnt] | w_grant_t;
                        r_state_t <= w_grant_t;
                    end
                end
                WAIT: begin
                    if (mul_done) begin
                        r_prod   <= mul_product;
                        r_prod_t <= mul_product_t | mul_done_t | r_state_t;
                        r_rv_t   <= r_state_t | mul_done_t;
                    end
                end
                RESPOND: begin
                    r_rr      <= (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                    r_state_t <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // outputs decode registers only; no input reaches an output combinationally
    assign mul_start      = (r_state == ISSUE);
    assign mul_start_t    = (r_state == ISSUE) & r_state_t;
    assign mul_a          = r_a;
    assign mul_b          = r_b;
    assign mul_op_t       = r_op_t;
    assign resp_valid     = (r_state == RESPOND) ? (NREQ'(1) << r_gnt) : '0;
    assign resp_valid_t   = (r_state == RESPOND) & r_rv_t;
    assign resp_product   = r_prod;
    assign resp_product_t = r_prod_t;
    assign busy           = (r_state != IDLE);

endmodule
